// File: rtl/bus_initiator.sv
// bus_initiator: master end of the daisy-chained register bus.
//
// Accepts one host command at a time (valid/ready), drives it onto the chain
// as a single-cycle valid pulse, then waits for the same address to come back
// at the end of the chain. Once it returns, or once the wait times out, it
// presents a response to the host until the host takes it.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   cmd_addr_i / cmd_wdata_i /   host command fields
//   cmd_rw_i (1 = write)
//   cmd_valid_i / cmd_ready_o    command handshake
//   rsp_addr_o / rsp_rdata_o /   response fields (rdata is 0 on timeout)
//   rsp_rw_o / rsp_timeout_o
//   rsp_valid_o / rsp_ready_i    response handshake
//   addr_o / wdata_o / rdata_o / bus out to the first core (rdata_o is always 0)
//   rw_o / valid_o
//   addr_i / wdata_i / rdata_i / bus in from the last core (wdata_i is unused)
//   rw_i / valid_i
module bus_initiator #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    input  logic                  cmd_rw_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,

    output logic [ADDR_WIDTH-1:0] rsp_addr_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_rw_o,
    output logic                  rsp_timeout_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,

    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rw_o,
    output logic                  valid_o,

    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  rw_i,
    input  logic                  valid_i
);

    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES);
    // The counter is cleared in ISSUE and reads 0 in the first WAIT cycle, so
    // its next value reaching TIMEOUT_CYCLES-1 means the response lands exactly
    // TIMEOUT_CYCLES cycles after the valid_o pulse.
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rw_q, rw_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  timeout_q, timeout_d;

    logic match;
    assign match = valid_i && (addr_i == addr_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
                    rw_d    = cmd_rw_i;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // A return on the last wait cycle still counts as a normal response.
                if (match) begin
                    rdata_d   = rdata_i;
                    timeout_d = 1'b0;
                    state_d   = StResp;
                end else if (cnt_q == CntLast) begin
                    rdata_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

    assign cmd_ready_o   = (state_q == StIdle);

    assign valid_o       = (state_q == StIssue);
    assign addr_o        = addr_q;
    assign wdata_o       = wdata_q;
    assign rw_o          = rw_q;
    assign rdata_o       = '0;

    assign rsp_valid_o   = (state_q == StResp);
    assign rsp_addr_o    = addr_q;
    assign rsp_rw_o      = rw_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_timeout_o = timeout_q;

    // Returning wdata/rw carry nothing the initiator needs.
    logic unused_bus_in;
    assign unused_bus_in = ^{wdata_i, rw_i};

endmodule

// File: tb/tb_bus_initiator.sv
module tb_bus_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cmd_addr_i, cmd_wdata_i;
    logic        cmd_rw_i, cmd_valid_i, cmd_ready_o;
    logic [15:0] rsp_addr_o, rsp_rdata_o;
    logic        rsp_rw_o, rsp_timeout_o, rsp_valid_o, rsp_ready_i;
    logic [15:0] addr_o, wdata_o, rdata_o;
    logic        rw_o, valid_o;
    logic [15:0] addr_i, wdata_i, rdata_i;
    logic        rw_i, valid_i;

    int vectors     = 0;
    int miscompares = 0;

    // Loopback responder: 3-cycle chain latency, rdata = addr ^ rdata_xor.
    logic        resp_en   = 1'b0;
    logic [15:0] rdata_xor = 16'h0000;
    logic        man_valid = 1'b0;
    logic [15:0] man_addr  = 16'h0000;
    logic [15:0] man_rdata = 16'h0000;
    logic        p1_v = 1'b0, p2_v = 1'b0, p3_v = 1'b0;
    logic [15:0] p1_a = 16'h0, p2_a = 16'h0, p3_a = 16'h0;

    always @(posedge clk) begin
        p1_v <= valid_o; p1_a <= addr_o;
        p2_v <= p1_v;    p2_a <= p1_a;
        p3_v <= p2_v;    p3_a <= p2_a;
    end

    assign valid_i = resp_en ? p3_v : man_valid;
    assign addr_i  = resp_en ? p3_a : man_addr;
    assign rdata_i = resp_en ? (p3_a ^ rdata_xor) : man_rdata;
    assign wdata_i = 16'h0000;
    assign rw_i    = 1'b0;

    always #5 clk = ~clk;

    bus_initiator #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(16),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_rw_i(cmd_rw_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .rsp_addr_o(rsp_addr_o), .rsp_rdata_o(rsp_rdata_o), .rsp_rw_o(rsp_rw_o),
        .rsp_timeout_o(rsp_timeout_o), .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o),
        .valid_o(valid_o),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i),
        .valid_i(valid_i)
    );

    // valid_o must never be high two cycles running.
    logic prev_valid_o = 1'b0;
    always @(posedge clk) begin
        if (valid_o) begin
            vectors++;
            if (prev_valid_o) begin
                miscompares++;
                $display("FAIL valid_o_single_pulse: got two consecutive cycles, required one");
            end
        end
        prev_valid_o = valid_o;
    end

    // Present a command for one edge; returns at the negedge of the ISSUE cycle.
    task automatic issue_cmd(input logic [15:0] a, input logic [15:0] d, input logic rw);
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        cmd_rw_i    = rw;
        cmd_valid_i = 1'b1;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        cmd_addr_i  = 16'hFFFF;
        cmd_wdata_i = 16'hFFFF;
        cmd_rw_i    = ~rw;
    endtask

    // Cycles from the current negedge until rsp_valid_o, or -1 if it never comes.
    task automatic wait_rsp(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (cmd_ready_o !== 1'b1) begin
            miscompares++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready_o);
        end
        vectors++;
        if ({valid_o, rsp_valid_o, rsp_timeout_o, rw_o, rsp_rw_o} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b required 00000",
                     {valid_o, rsp_valid_o, rsp_timeout_o, rw_o, rsp_rw_o});
        end
        vectors++;
        if ({addr_o, wdata_o, rdata_o, rsp_addr_o, rsp_rdata_o} !== 80'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h required 0",
                     {addr_o, wdata_o, rdata_o, rsp_addr_o, rsp_rdata_o});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int lat;
        resp_en = 1'b1; rdata_xor = 16'h0000;
        issue_cmd(16'h0003, 16'h0001, 1'b1);
        vectors++;
        if ({valid_o, cmd_ready_o} !== 2'b10) begin
            miscompares++; $display("FAIL write_issue: valid/ready got %b required 10",
                                    {valid_o, cmd_ready_o});
        end
        vectors++;
        if ({addr_o, wdata_o, rw_o, rdata_o} !== {16'h0003, 16'h0001, 1'b1, 16'h0000}) begin
            miscompares++; $display("FAIL write_bus: got %h/%h/%b/%h required 0003/0001/1/0000",
                                    addr_o, wdata_o, rw_o, rdata_o);
        end
        wait_rsp(20, lat);
        vectors++;
        if (lat !== 4) begin
            miscompares++; $display("FAIL write_latency: got %0d required 4", lat);
        end
        vectors++;
        if ({rsp_addr_o, rsp_rw_o, rsp_timeout_o, rsp_rdata_o} !== {16'h0003, 1'b1, 1'b0, 16'h0003})
        begin
            miscompares++; $display("FAIL write_rsp: got %h/%b/%b/%h required 0003/1/0/0003",
                                    rsp_addr_o, rsp_rw_o, rsp_timeout_o, rsp_rdata_o);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        vectors++;
        if ({rsp_valid_o, cmd_ready_o} !== 2'b01) begin
            miscompares++; $display("FAIL write_handshake: rsp_valid/ready got %b required 01",
                                    {rsp_valid_o, cmd_ready_o});
        end
    endtask

    task automatic test_read();
        int lat;
        resp_en = 1'b1; rdata_xor = 16'hBEEB;  // 0x0004 ^ 0xBEEB = 0xBEEF
        issue_cmd(16'h0004, 16'h0000, 1'b0);
        wait_rsp(20, lat);
        vectors++;
        if (lat !== 4) begin
            miscompares++; $display("FAIL read_latency: got %0d required 4", lat);
        end
        cmd_valid_i = 1'b1; cmd_addr_i = 16'h0099;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({rsp_valid_o, cmd_ready_o, rsp_timeout_o, rsp_rw_o} !== 4'b1000 ||
                rsp_rdata_o !== 16'hBEEF || rsp_addr_o !== 16'h0004) begin
                miscompares++;
                $display("FAIL read_hold[%0d]: got v=%b rdy=%b to=%b rw=%b d=%h a=%h required 1 0 0 0 BEEF 0004",
                         i, rsp_valid_o, cmd_ready_o, rsp_timeout_o, rsp_rw_o, rsp_rdata_o, rsp_addr_o);
            end
            @(negedge clk);
        end
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        vectors++;
        if ({rsp_valid_o, cmd_ready_o} !== 2'b01) begin
            miscompares++; $display("FAIL read_handshake: got %b required 01",
                                    {rsp_valid_o, cmd_ready_o});
        end
    endtask

    task automatic test_timeout();
        int lat;
        resp_en = 1'b0; man_valid = 1'b0;
        issue_cmd(16'h0010, 16'h0000, 1'b0);
        wait_rsp(100, lat);
        vectors++;
        if (lat !== 64) begin
            miscompares++; $display("FAIL timeout_latency: got %0d required 64", lat);
        end
        vectors++;
        if ({rsp_timeout_o, rsp_rdata_o, cmd_ready_o} !== {1'b1, 16'h0000, 1'b0}) begin
            miscompares++; $display("FAIL timeout_rsp: got to=%b d=%h rdy=%b required 1 0000 0",
                                    rsp_timeout_o, rsp_rdata_o, cmd_ready_o);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        vectors++;
        if ({rsp_valid_o, cmd_ready_o} !== 2'b01) begin
            miscompares++; $display("FAIL timeout_handshake: got %b required 01",
                                    {rsp_valid_o, cmd_ready_o});
        end
    endtask

    task automatic test_stray();
        resp_en = 1'b0;
        issue_cmd(16'h0005, 16'h0000, 1'b0);
        for (int k = 1; k <= 63; k++) begin
            @(negedge clk);
            man_valid = 1'b0;
            if (k == 5) begin
                man_valid = 1'b1; man_addr = 16'h0007; man_rdata = 16'h1111;
            end
            if (k == 63) begin
                vectors++;
                if (rsp_valid_o !== 1'b0) begin
                    miscompares++; $display("FAIL stray_ignored: rsp_valid got %b required 0",
                                            rsp_valid_o);
                end
                man_valid = 1'b1; man_addr = 16'h0005; man_rdata = 16'h5A5A;
            end
        end
        @(negedge clk);
        man_valid = 1'b0;
        vectors++;
        if ({rsp_valid_o, rsp_timeout_o, rsp_rdata_o} !== {1'b1, 1'b0, 16'h5A5A}) begin
            miscompares++; $display("FAIL stray_last_cycle_match: got v=%b to=%b d=%h required 1 0 5A5A",
                                    rsp_valid_o, rsp_timeout_o, rsp_rdata_o);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        // Bus return while idle must not produce a response.
        man_valid = 1'b1; man_addr = 16'h0005; man_rdata = 16'h2222;
        @(negedge clk);
        man_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({rsp_valid_o, cmd_ready_o} !== 2'b01) begin
                miscompares++; $display("FAIL idle_valid_i[%0d]: got %b required 01",
                                        i, {rsp_valid_o, cmd_ready_o});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        resp_en = 1'b0;
        issue_cmd(16'h0020, 16'h0000, 1'b1);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if ({cmd_ready_o, valid_o, rsp_valid_o} !== 3'b100 || addr_o !== 16'h0000) begin
            miscompares++; $display("FAIL reset_mid: got rdy/v/rv=%b addr=%h required 100 0000",
                                    {cmd_ready_o, valid_o, rsp_valid_o}, addr_o);
        end
        man_valid = 1'b1; man_addr = 16'h0020; man_rdata = 16'h3333;
        @(negedge clk);
        man_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({rsp_valid_o, cmd_ready_o} !== 2'b01) begin
                miscompares++; $display("FAIL reset_mid_late[%0d]: got %b required 01",
                                        i, {rsp_valid_o, cmd_ready_o});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int issued = 0;
        int got    = 0;
        resp_en = 1'b1; rdata_xor = 16'h1200;
        rsp_ready_i = 1'b1;
        cmd_addr_i = 16'h0000; cmd_wdata_i = 16'h0000; cmd_rw_i = 1'b0;
        cmd_valid_i = 1'b1;
        for (int c = 0; c < 400 && got < 16; c++) begin
            @(negedge clk);
            if (valid_o) begin
                vectors++;
                if (issued != got || addr_o !== 16'(issued)) begin
                    miscompares++; $display("FAIL b2b_issue: issued=%0d responded=%0d addr=%h required %0d %0d %h",
                                            issued, got, addr_o, issued, issued, 16'(issued));
                end
                issued++;
                cmd_addr_i = 16'(issued);
                if (issued == 16) cmd_valid_i = 1'b0;
            end
            if (rsp_valid_o) begin
                vectors++;
                if (rsp_addr_o !== 16'(got) || rsp_rdata_o !== (16'h1200 | 16'(got)) ||
                    rsp_timeout_o !== 1'b0) begin
                    miscompares++; $display("FAIL b2b_rsp[%0d]: got a=%h d=%h to=%b required %h %h 0",
                                            got, rsp_addr_o, rsp_rdata_o, rsp_timeout_o,
                                            16'(got), 16'h1200 | 16'(got));
                end
                got++;
            end
        end
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        vectors++;
        if (got !== 16 || issued !== 16) begin
            miscompares++; $display("FAIL b2b_count: got issued=%0d responses=%0d required 16 16",
                                    issued, got);
        end
    endtask

    initial begin
        cmd_addr_i = 16'h0; cmd_wdata_i = 16'h0; cmd_rw_i = 1'b0; cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_stray();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within 100000 time units");
        $fatal(1);
    end

endmodule
